csi_frame_monitor: RTL
======================

Name: csi_frame_monitor

Overview:
- Parametrised on-board stream monitor sitting directly after csi_rx_ice40 in the word_clk domain, replacing ad-hoc LED/payload debug logic in board tops.
- Tracks frame/line structure of the decoded CSI-2 payload stream: frame count, lines per frame, words per line, and line-length consistency errors.
- Drives a configurable LED bank and a heartbeat for bring-up.

Parameters:
- LANES, 2, CSI lane count; payload width is 8*LANES bits.
- NLEDS, 5, width of LED output bank (1..8*LANES).
- CNT_W, 16, width of frame/line/word counters.
- HB_BITS, 23, heartbeat divider width; heartbeat toggles at clock/2^HB_BITS.

Ports:
- clock  input  1  word clock from receiver.
- reset  input  1  synchronous, active-high reset.
- in_frame  input  1  high between frame start and frame end.
- in_line  input  1  high during a video line packet.
- payload_data  input  8*LANES  payload word.
- payload_enable  input  1  payload word valid.
- payload_frame  input  1  payload belongs to active frame.
- clear_err  input  1  one-cycle pulse clears sticky error flags.
- frame_count  output  CNT_W  completed frames, wraps.
- last_line_count  output  CNT_W  lines in last completed frame.
- last_line_words  output  CNT_W  words in first line of last completed frame.
- stats_valid  output  1  one-cycle pulse when the stats outputs update.
- line_len_err  output  1  sticky: a line length differed from the first line of its frame.
- trunc_err  output  1  sticky: frame ended while a line was open.
- leds  output  NLEDS  payload_data[NLEDS-1:0] of the last accepted word.
- heartbeat  output  1  divider MSB.

Behaviour:
- Reset: all outputs 0, all counters 0, FSM in IDLE, previous-value edge registers 0.
- Edge detection: rise/fall are computed from the current input against its value registered in the previous cycle.
- Accepted word: payload_enable && payload_frame && in_line in FSM state LINE.
- FSM states: IDLE, FRAME, LINE.
- IDLE -> FRAME on in_frame rise:
  - clear line_cnt and ref_len;
  - set first_line = 1.
- FRAME -> LINE on in_line rise: clear word_cnt.
- LINE, each accepted word: word_cnt++ (saturates at 2^CNT_W-1).
- LINE, each accepted word: leds <= payload_data[NLEDS-1:0].
- LINE -> FRAME on in_line fall: line_cnt++ (saturating).
  - If first_line: ref_len <= word_cnt, clear first_line.
  - Else if word_cnt != ref_len: set line_len_err.
- FRAME or LINE -> IDLE on in_frame fall:
  - frame_count++ (wraps modulo 2^CNT_W);
  - last_line_count <= line_cnt, last_line_words <= ref_len;
  - stats_valid pulses high for exactly one cycle.
  - Outputs are visible on the clock edge after the fall-detect cycle.
- in_frame fall while in LINE:
  - set trunc_err;
  - the open line is not counted and not length-checked.
- Simultaneous in_line fall and in_frame fall in the same cycle:
  - the line closes normally (counted and checked), then the frame closes;
  - trunc_err is not set.
- in_line rise while in IDLE is ignored; FSM stays IDLE and counts nothing.
- Frame with zero lines: last_line_count = 0, last_line_words = 0, stats_valid still pulses.
- clear_err clears line_len_err and trunc_err.
  - An error event in the same cycle as clear_err wins: the flag ends set.
- reset mid-frame returns to IDLE; the frame in progress is discarded with no stats_valid pulse.
- heartbeat: free-running HB_BITS divider; heartbeat = MSB; unaffected by the stream.

Optional Feature:
- Macro: CSI_MON_CHECKSUM_EN.
- When defined:
  - adds output frame_csum [8*LANES-1:0];
  - running XOR of all accepted words, cleared on in_frame rise;
  - latched into frame_csum with the same timing as the other stats outputs.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- LANES=2, 3 frames of 4 lines x 10 accepted words -> after each frame, stats_valid pulses once; frame_count = 1, 2, 3; last_line_count = 4; last_line_words = 10; no errors.
- Frame whose lines have 10, 10, 9, 10 words -> line_len_err = 1 after line 3 and stays high; pulse clear_err -> 0.
- in_frame falls while in_line is high after 5 words -> trunc_err = 1; last_line_count excludes the open line.
- CNT_W=4, 17 frames -> frame_count wraps to 1; a line of 20 words gives last_line_words = 15 (saturated).
- Assert reset mid-line, then run one clean 2x3 frame -> no stats_valid pulse for the aborted frame; clean frame reports frame_count = 1, last_line_count = 2, last_line_words = 3.
- With CSI_MON_CHECKSUM_EN, one frame of words 0x0001, 0x0002, 0x0004 -> frame_csum = 0x0007; last word 0x0004 -> leds = 5'b00100.

Source files
------------

// File: rtl/csi_frame_monitor.sv
// Frame/line structure monitor for the decoded CSI-2 payload stream (word clock domain).
// Define CSI_MON_CHECKSUM_EN to add the per-frame XOR checksum output frame_csum.
module csi_frame_monitor #(
    parameter int LANES   = 2,
    parameter int NLEDS   = 5,
    parameter int CNT_W   = 16,
    parameter int HB_BITS = 23
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_frame,
    input  logic                 in_line,
    input  logic [8*LANES-1:0]   payload_data,
    input  logic                 payload_enable,
    input  logic                 payload_frame,
    input  logic                 clear_err,
    output logic [CNT_W-1:0]     frame_count,
    output logic [CNT_W-1:0]     last_line_count,
    output logic [CNT_W-1:0]     last_line_words,
    output logic                 stats_valid,
    output logic                 line_len_err,
    output logic                 trunc_err,
    output logic [NLEDS-1:0]     leds,
    output logic                 heartbeat
`ifdef CSI_MON_CHECKSUM_EN
    ,
    output logic [8*LANES-1:0]   frame_csum
`endif
);

    typedef enum logic [1:0] {IDLE, FRAME, LINE} state_t;

    state_t             state;
    logic               in_frame_q;
    logic               in_line_q;
    logic [CNT_W-1:0]   line_cnt;
    logic [CNT_W-1:0]   word_cnt;
    logic [CNT_W-1:0]   ref_len;
    logic               first_line;
    logic [HB_BITS-1:0] hb_cnt;

    logic               frame_rise;
    logic               frame_fall;
    logic               line_rise;
    logic               line_fall;
    logic               accept;
    logic               line_close;
    logic               frame_close;
    logic               len_mismatch;
    logic               trunc_event;
    logic [CNT_W-1:0]   line_cnt_nxt;
    logic [CNT_W-1:0]   ref_len_nxt;

    // A line closing in the same cycle as its frame must be folded into the
    // frame stats, so the post-close line count and reference length are
    // computed here and used both for the line and the frame update.
    always_comb begin
        frame_rise   = in_frame & ~in_frame_q;
        frame_fall   = ~in_frame & in_frame_q;
        line_rise    = in_line & ~in_line_q;
        line_fall    = ~in_line & in_line_q;
        accept       = (state == LINE) && payload_enable && payload_frame && in_line;
        line_close   = (state == LINE) && line_fall;
        frame_close  = (state != IDLE) && frame_fall;
        trunc_event  = (state == LINE) && frame_fall && !line_fall;
        len_mismatch = line_close && !first_line && (word_cnt != ref_len);
        line_cnt_nxt = line_cnt;
        ref_len_nxt  = ref_len;
        if (line_close) begin
            if (line_cnt != '1)
                line_cnt_nxt = line_cnt + CNT_W'(1);
            if (first_line)
                ref_len_nxt = word_cnt;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= IDLE;
            in_frame_q      <= 1'b0;
            in_line_q       <= 1'b0;
            line_cnt        <= '0;
            word_cnt        <= '0;
            ref_len         <= '0;
            first_line      <= 1'b0;
            hb_cnt          <= '0;
            frame_count     <= '0;
            last_line_count <= '0;
            last_line_words <= '0;
            stats_valid     <= 1'b0;
            line_len_err    <= 1'b0;
            trunc_err       <= 1'b0;
            leds            <= '0;
        end else begin
            in_frame_q   <= in_frame;
            in_line_q    <= in_line;
            hb_cnt       <= hb_cnt + HB_BITS'(1);
            stats_valid  <= 1'b0;
            // Error events take priority over a concurrent clear.
            line_len_err <= (line_len_err & ~clear_err) | len_mismatch;
            trunc_err    <= (trunc_err & ~clear_err) | trunc_event;

            if (accept) begin
                leds <= payload_data[NLEDS-1:0];
                if (word_cnt != '1)
                    word_cnt <= word_cnt + CNT_W'(1);
            end

            if (line_close) begin
                line_cnt   <= line_cnt_nxt;
                ref_len    <= ref_len_nxt;
                first_line <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (frame_rise) begin
                        state      <= FRAME;
                        line_cnt   <= '0;
                        ref_len    <= '0;
                        first_line <= 1'b1;
                    end
                end
                FRAME: begin
                    if (frame_fall)
                        state <= IDLE;
                    else if (line_rise) begin
                        state    <= LINE;
                        word_cnt <= '0;
                    end
                end
                LINE: begin
                    if (frame_fall)
                        state <= IDLE;
                    else if (line_fall)
                        state <= FRAME;
                end
                default: state <= IDLE;
            endcase

            if (frame_close) begin
                frame_count     <= frame_count + CNT_W'(1);
                last_line_count <= line_cnt_nxt;
                last_line_words <= ref_len_nxt;
                stats_valid     <= 1'b1;
            end
        end
    end

    assign heartbeat = hb_cnt[HB_BITS-1];

`ifdef CSI_MON_CHECKSUM_EN
    logic [8*LANES-1:0] csum_acc;

    always_ff @(posedge clock) begin
        if (reset) begin
            csum_acc   <= '0;
            frame_csum <= '0;
        end else begin
            if (state == IDLE && frame_rise)
                csum_acc <= '0;
            else if (accept)
                csum_acc <= csum_acc ^ payload_data;
            if (frame_close)
                frame_csum <= csum_acc;
        end
    end
`else
    // Only the LED slice of the payload is consumed without the checksum.
    logic unused_payload_bits;
    assign unused_payload_bits = ^payload_data;
`endif

endmodule
